tt_pin_host: RTL and testbench

TT_PIN_HOST -- requirements
Module: tt_pin_host

---
 rtl/tt_pin_host_pkg.sv | 28 ++
 rtl/tt_pin_host_fifo.sv | 53 +++++
 rtl/tt_pin_host.sv | 140 ++++++++++++++
 tb/tb_tt_pin_host.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_host_pkg.sv
// Shared types and constants for the TinyTapeout pin host.
// Optional compare feature is enabled by defining TT_PIN_HOST_CMP_EN.
package tt_pin_host_pkg;

   localparam int unsigned RSP_W = 16;

   typedef enum logic [1:0] {
      OP_SET_UI  = 2'd0,
      OP_SET_UIO = 2'd1,
      OP_WAIT    = 2'd2,
      OP_SAMPLE  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_SAMPLE = 2'd3
   } state_e;

   // Design-driven bits come from uio_out, the rest reflect what the host drives.
   function automatic logic [7:0] merge_uio(input logic [7:0] oe,
                                            input logic [7:0] dout,
                                            input logic [7:0] din);
      return (oe & dout) | (~oe & din);
   endfunction

endpackage

// File: rtl/tt_pin_host_fifo.sv
// Response FIFO for tt_pin_host: power-of-two depth, push+pop legal when full.
module tt_pin_host_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tt_pin_host.sv
// Command-driven pin host for a TinyTapeout user design.
// Define TT_PIN_HOST_CMP_EN to compare sampled uo_out against the SAMPLE operand.
module tt_pin_host
   import tt_pin_host_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SETTLE     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [7:0]       cmd_data,
   output logic [7:0]       ui_in,
   output logic [7:0]       uio_in,
   output logic             ena,
   input  logic [7:0]       uo_out,
   input  logic [7:0]       uio_out,
   input  logic [7:0]       uio_oe,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [RSP_W-1:0] rsp_data,
   output logic [7:0]       mismatch_cnt
);

   state_e           r_state;
   logic [7:0]       r_cnt;
   logic [7:0]       r_ui;
   logic [7:0]       r_uio;
   logic             r_ena;
   logic             r_ready;
   logic             w_accept;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic [RSP_W-1:0] w_sample;

   assign w_accept  = cmd_valid & r_ready;
   assign w_pop     = rsp_ready & ~w_empty;
   assign w_push    = (r_state == ST_SAMPLE) & (~w_full | w_pop);
   assign w_sample  = {merge_uio(uio_oe, uio_out, r_uio), uo_out};
   assign cmd_ready = r_ready;
   assign ui_in     = r_ui;
   assign uio_in    = r_uio;
   assign ena       = r_ena;
   assign rsp_valid = ~w_empty;

   // Command sequencer; r_ready tracks "next state is IDLE" so it is low in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'h00;
         r_ui    <= 8'h00;
         r_uio   <= 8'h00;
         r_ena   <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_ena <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  case (op_e'(cmd_op))
                     OP_SET_UI: begin
                        r_ui    <= cmd_data;
                        r_cnt   <= 8'(SETTLE - 1);
                        r_state <= ST_SETTLE;
                     end
                     OP_SET_UIO: begin
                        r_uio   <= cmd_data;
                        r_cnt   <= 8'(SETTLE - 1);
                        r_state <= ST_SETTLE;
                     end
                     OP_WAIT: begin
                        r_cnt   <= cmd_data;
                        r_state <= ST_WAIT;
                     end
                     default: r_state <= ST_SAMPLE;
                  endcase
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_SETTLE, ST_WAIT: begin
               if (r_cnt == 8'h00) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_SAMPLE: begin
               if (w_push) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   tt_pin_host_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RSP_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_sample),
      .i_pop   (w_pop),
      .o_rdata (rsp_data),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

`ifdef TT_PIN_HOST_CMP_EN
   logic [7:0] r_expect;
   logic [7:0] r_mismatch;

   // Expected value is latched at accept and compared in the push cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_expect   <= 8'h00;
         r_mismatch <= 8'h00;
      end else begin
         if (w_accept && (op_e'(cmd_op) == OP_SAMPLE)) r_expect <= cmd_data;
         if (w_push && (uo_out != r_expect) && (r_mismatch != 8'hFF))
            r_mismatch <= r_mismatch + 8'd1;
      end
   end

   assign mismatch_cnt = r_mismatch;
`else
   assign mismatch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_tt_pin_host.sv
// Scoreboard bench for tt_pin_host (FIFO_DEPTH=4, SETTLE=2).
module tb_tt_pin_host;
   import tt_pin_host_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic [7:0]  ui_in;
   logic [7:0]  uio_in;
   logic        ena;
   logic [7:0]  uo_out;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [7:0]  mismatch_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] sb[$];
   logic [7:0]  exp_uio = 8'h00;
   logic [15:0] last_rsp = 16'h0000;
   logic [7:0]  ui_snap;
   logic [7:0]  uio_snap;
   int          low;

   always #5 clk = ~clk;

   tt_pin_host #(.FIFO_DEPTH(4), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .ui_in(ui_in), .uio_in(uio_in),
      .ena(ena), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mismatch_cnt(mismatch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Responses leave the DUT at the posedge following a negedge with valid&ready.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            chk("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
            last_rsp = rsp_data;
         end
      end
   end

   // Entered and left on a negedge; returns the number of cycles cmd_ready stayed low.
   task automatic send(input logic [1:0] op, input logic [7:0] data, output int n_low);
      int n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (op == 2'(OP_SET_UIO)) exp_uio = data;
      @(negedge clk);
      ui_snap  = ui_in;
      uio_snap = uio_in;
      n_low = 0;
      while (!cmd_ready && n_low < 400) begin
         n_low++;
         @(negedge clk);
      end
   endtask

   task automatic do_sample(input logic [7:0] cmp, output int n_low);
      sb.push_back({(uio_oe & uio_out) | (~uio_oe & exp_uio), uo_out});
      send(2'(OP_SAMPLE), cmp, n_low);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_left", 32'(sb.size()), 32'd0);
      chk("drain_valid", 32'(rsp_valid), 32'd0);
   endtask

   task automatic set_rsp_ready(input logic v);
      @(posedge clk);
      #1 rsp_ready = v;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
      uo_out = 8'h00; uio_out = 8'h00; uio_oe = 8'h00; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ui", 32'(ui_in), 32'h0);
      chk("rst_uio", 32'(uio_in), 32'h0);
      chk("rst_ena", 32'(ena), 32'h0);
      chk("rst_valid", 32'(rsp_valid), 32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h0);
      chk("rst_mis", 32'(mismatch_cnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ena", 32'(ena), 32'h1);
      chk("rel_ready", 32'(cmd_ready), 32'h1);

      send(2'(OP_SET_UI), 8'hA5, low);
      chk("set_ui_val", 32'(ui_snap), 32'hA5);
      chk("set_ui_low", 32'(low), 32'd2);

      uio_oe = 8'hF0; uio_out = 8'h30; uo_out = 8'h55;
      send(2'(OP_SET_UIO), 8'h0F, low);
      chk("set_uio_val", 32'(uio_snap), 32'h0F);
      chk("set_uio_low", 32'(low), 32'd2);
      do_sample(8'h55, low);
      chk("sample_low", 32'(low), 32'd1);
      drain();
      chk("rsp_3f55", 32'(last_rsp), 32'h3F55);

      send(2'(OP_WAIT), 8'd0, low);
      chk("wait0_low", 32'(low), 32'd1);
      send(2'(OP_WAIT), 8'd3, low);
      chk("wait3_low", 32'(low), 32'd4);

      for (int i = 0; i < 4; i++) begin
         uio_oe  = 8'($urandom);
         uio_out = 8'($urandom);
         uo_out  = 8'($urandom);
         send(2'(OP_SET_UIO), 8'($urandom), low);
         do_sample(uo_out, low);
      end
      drain();

      // Fill the FIFO, then stall a fifth SAMPLE until one pop frees a slot.
      set_rsp_ready(1'b0);
      uio_oe = 8'h00;
      for (int i = 0; i < 4; i++) begin
         uo_out = 8'(8'h10 + i);
         do_sample(uo_out, low);
      end
      uo_out = 8'h99;
      sb.push_back({exp_uio, uo_out});
      cmd_valid = 1'b1; cmd_op = 2'(OP_SAMPLE); cmd_data = 8'h99;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("stall_release", 32'(cmd_ready), 32'd1);
      chk("stall_sb_left", 32'(sb.size()), 32'd4);
      set_rsp_ready(1'b1);
      drain();

`ifdef TT_PIN_HOST_CMP_EN
      uo_out = 8'h13;
      do_sample(8'h12, low);
      drain();
      chk("cmp_one", 32'(mismatch_cnt), 32'd1);
      do_sample(8'h13, low);
      drain();
      chk("cmp_match", 32'(mismatch_cnt), 32'd1);
      for (int i = 0; i < 299; i++) do_sample(8'h12, low);
      drain();
      chk("cmp_sat", 32'(mismatch_cnt), 32'd255);
`else
      uo_out = 8'h13;
      do_sample(8'h12, low);
      drain();
      chk("cmp_tied", 32'(mismatch_cnt), 32'd0);
`endif

      // Reset in the middle of a WAIT with two responses queued.
      send(2'(OP_SET_UI), 8'h3C, low);
      set_rsp_ready(1'b0);
      do_sample(uo_out, low);
      do_sample(uo_out, low);
      chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
      cmd_valid = 1'b1; cmd_op = 2'(OP_WAIT); cmd_data = 8'd100;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ui", 32'(ui_in), 32'd0);
      chk("mid_rst_ena", 32'(ena), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
      sb.delete();
      exp_uio = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_mis", 32'(mismatch_cnt), 32'd0);
      set_rsp_ready(1'b1);
      uio_oe = 8'h0F; uio_out = 8'hA6; uo_out = 8'h7E;
      do_sample(uo_out, low);
      chk("post_rst_sample_low", 32'(low), 32'd1);
      drain();
      chk("post_rst_rsp", 32'(last_rsp), 32'h067E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
